accum_alu: RTL and testbench

Parametrised, pipelined signed add/subtract accumulator with valid/ready handshaking on both sides. It is the next generation of the team's registered add/sub-with-overflow datapath block and generalises it in three ways:
- operand width and counter width are parameters;
- operations can load from an input operand or accumulate onto the previous result;
- overflow is reported per result and also kept as a clearable sticky flag.

It sits between an operand source and a result consumer, and either side may stall.

---
 rtl/accum_alu_pkg.sv | 22 ++
 rtl/addsub_core.sv | 27 ++
 rtl/accum_alu.sv | 115 +++++++++++
 tb/tb_accum_alu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_alu_pkg.sv
// Shared types and default widths for the accum_alu accumulator.
package accum_alu_pkg;

    localparam int N_DEF     = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_LD_ADD  = 2'b00,
        OP_LD_SUB  = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    function automatic logic op_is_acc(input op_e op);
        return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
    endfunction

    function automatic logic op_is_sub(input op_e op);
        return (op == OP_LD_SUB) || (op == OP_ACC_SUB);
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational N-bit two's complement add/subtract with signed overflow.
module addsub_core #(
    parameter int N = 16
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         ovf_o
);

    logic [N-1:0] y_eff;
    logic [N-1:0] low;
    logic         c_msb_in;
    logic         c_msb_out;

    assign y_eff = y_i ^ {N{sub_i}};

    // Low N-1 bits summed separately so the carry into the MSB is visible.
    assign low       = {1'b0, x_i[N-2:0]} + {1'b0, y_eff[N-2:0]} + N'(sub_i);
    assign c_msb_in  = low[N-1];
    assign c_msb_out = (x_i[N-1] & y_eff[N-1]) | (c_msb_in & (x_i[N-1] ^ y_eff[N-1]));

    assign sum_o = {x_i[N-1] ^ y_eff[N-1] ^ c_msb_in, low[N-2:0]};
    assign ovf_o = c_msb_in ^ c_msb_out;

endmodule

// File: rtl/accum_alu.sv
// Two-stage pipelined add/sub accumulator with valid/ready on both sides.
// Define ACCUM_ALU_SAT_EN to clamp Z on overflow instead of wrapping.
module accum_alu
    import accum_alu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [1:0]       Op,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [N-1:0]     Z,
    output logic             Overflow,
    output logic             Sticky_ovf,
    output logic [CNT_W-1:0] Op_count
);

    logic             s1_v_q;
    op_e              s1_op_q;
    logic [N-1:0]     s1_a_q;
    logic [N-1:0]     s1_b_q;
    logic [N-1:0]     z_q, z_d;
    logic             ovf_q;
    logic             out_valid_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             advance;
    logic             accept;
    logic [N-1:0]     core_x;
    logic [N-1:0]     core_sum;
    logic             core_ovf;

    assign advance  = s1_v_q & (~out_valid_q | Out_ready);
    assign In_ready = ~Clear & (~s1_v_q | advance);
    assign accept   = In_valid & In_ready;

    // ACC ops read the committed Z; stage 2 is its only writer, so no hazard.
    assign core_x = op_is_acc(s1_op_q) ? z_q : s1_a_q;

    addsub_core #(.N(N)) u_core (
        .x_i   (core_x),
        .y_i   (s1_b_q),
        .sub_i (op_is_sub(s1_op_q)),
        .sum_o (core_sum),
        .ovf_o (core_ovf)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        z_d   = core_sum;
`ifdef ACCUM_ALU_SAT_EN
        // A negative-looking sum on overflow means the true result was too positive.
        if (core_ovf) begin
            z_d = core_sum[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
        end
`endif
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (Reset) begin
            s1_v_q      <= 1'b0;
            s1_op_q     <= OP_LD_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else if (Clear) begin
            s1_v_q      <= 1'b0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                s1_v_q  <= 1'b1;
                s1_op_q <= op_e'(Op);
                s1_a_q  <= A;
                s1_b_q  <= B;
            end else if (advance) begin
                s1_v_q  <= 1'b0;
            end

            if (advance) begin
                z_q         <= z_d;
                ovf_q       <= core_ovf;
                out_valid_q <= 1'b1;
                sticky_q    <= sticky_q | core_ovf;
                cnt_q       <= cnt_d;
            end else if (Out_ready & out_valid_q) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign Z          = z_q;
    assign Overflow   = ovf_q;
    assign Out_valid  = out_valid_q;
    assign Sticky_ovf = sticky_q;
    assign Op_count   = cnt_q;

endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu: integer reference model plus directed scenarios.
module tb_accum_alu;

    localparam int N = 16;

`ifdef ACCUM_ALU_SAT_EN
    localparam logic [15:0] OVF_Z = 16'h7FFF;
`else
    localparam logic [15:0] OVF_Z = 16'h8000;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op;
    logic [15:0] a, b, z;
    logic        ovf, sticky;
    logic [7:0]  cnt;

    logic        c2_in_valid, c2_in_ready, c2_out_valid, c2_ovf, c2_sticky;
    logic [15:0] c2_z;
    logic [1:0]  c2_cnt;

    accum_alu #(.N(N), .CNT_W(8)) u_dut (
        .Clock(clk), .Reset(rst), .Clear(clr),
        .In_valid(in_valid), .In_ready(in_ready),
        .Op(op), .A(a), .B(b),
        .Out_valid(out_valid), .Out_ready(out_ready),
        .Z(z), .Overflow(ovf), .Sticky_ovf(sticky), .Op_count(cnt)
    );

    accum_alu #(.N(N), .CNT_W(2)) u_dut_cnt2 (
        .Clock(clk), .Reset(rst), .Clear(1'b0),
        .In_valid(c2_in_valid), .In_ready(c2_in_ready),
        .Op(2'b00), .A(16'h0001), .B(16'h0001),
        .Out_valid(c2_out_valid), .Out_ready(1'b1),
        .Z(c2_z), .Overflow(c2_ovf), .Sticky_ovf(c2_sticky), .Op_count(c2_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] z;
        logic        ovf;
        logic        sticky;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   acc_m    = 0;
    logic sticky_m = 1'b0;
    int   cnt_m    = 0;

    // Monitor pops on every output handshake; the model pushes on every input handshake.
    always @(negedge clk) begin : scoreboard
        exp_t        e;
        exp_t        got;
        int          x;
        int          full;
        logic [15:0] r;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got Z=0x%0h, expected no result", z);
            end else begin
                got = sb_q.pop_front();
                check("z", 32'(z), 32'(got.z));
                check("overflow", 32'(ovf), 32'(got.ovf));
                check("sticky_ovf", 32'(sticky), 32'(got.sticky));
                check("op_count", 32'(cnt), 32'(got.cnt));
            end
        end
        if (rst || clr) begin
            sb_q.delete();
            acc_m    = 0;
            sticky_m = 1'b0;
            cnt_m    = 0;
        end else if (in_valid && in_ready) begin
            x    = op[1] ? acc_m : int'($signed(a));
            full = op[0] ? x - int'($signed(b)) : x + int'($signed(b));
            e.ovf = (full > 32767) || (full < -32768);
`ifdef ACCUM_ALU_SAT_EN
            if (full > 32767)       full = 32767;
            else if (full < -32768) full = -32768;
`endif
            r        = full[15:0];
            acc_m    = int'($signed(r));
            sticky_m = sticky_m | e.ovf;
            if (cnt_m < 255) cnt_m++;
            e.z      = r;
            e.sticky = sticky_m;
            e.cnt    = cnt_m[7:0];
            sb_q.push_back(e);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1);
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_z"}, 32'(z), 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_sticky"}, 32'(sticky), 32'h0);
        check({tag, "_op_count"}, 32'(cnt), 32'h0);
        check({tag, "_overflow"}, 32'(ovf), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv);
        in_valid = v;
        op       = o;
        a        = av;
        b        = bv;
    endtask

    int accepted;

    initial begin
        rst = 1'b1; clr = 1'b0; out_ready = 1'b0; c2_in_valid = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");
        check("cnt2_reset", 32'(c2_cnt), 32'h0);
        out_ready = 1'b1;

        // Load then accumulate, back to back.
        @(posedge clk); #1 drive(1'b1, 2'b00, 16'h0003, 16'h0004);
        @(posedge clk); #1 drive(1'b1, 2'b11, 16'h1234, 16'h0009);
        @(posedge clk); #1 drive(1'b0, 2'b00, 16'h0, 16'h0);
        check("ldacc_z1", 32'(z), 32'h0007);
        check("ldacc_valid1", 32'(out_valid), 32'h1);
        @(posedge clk); #1;
        check("ldacc_z2", 32'(z), 32'hFFFE);
        check("ldacc_ovf", 32'(ovf), 32'h0);
        check("ldacc_cnt", 32'(cnt), 32'h2);

        // Overflow then a clean result: sticky must hold.
        @(posedge clk); #1 drive(1'b1, 2'b00, 16'h7FFF, 16'h0001);
        @(posedge clk); #1 drive(1'b1, 2'b00, 16'h0001, 16'h0001);
        @(posedge clk); #1 drive(1'b0, 2'b00, 16'h0, 16'h0);
        check("ovf_z", 32'(z), 32'(OVF_Z));
        check("ovf_flag", 32'(ovf), 32'h1);
        check("ovf_sticky", 32'(sticky), 32'h1);
        @(posedge clk); #1;
        check("ovf2_z", 32'(z), 32'h0002);
        check("ovf2_flag", 32'(ovf), 32'h0);
        check("ovf2_sticky", 32'(sticky), 32'h1);

        // Backpressure: three ACC_ADD +1 from Z=0 with the consumer stalled.
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 16'hA5A5, 16'h0001);
        accepted = 0;
        repeat (4) begin
            @(negedge clk); if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        check("bp_accepted", 32'(accepted), 32'h2);
        check("bp_in_ready_low", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1 check("bp_in_ready_comb", 32'(in_ready), 32'h1);
        for (int i = 0; i < 10 && accepted < 3; i++) begin
            @(negedge clk); if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        drive(1'b0, 2'b00, 16'h0, 16'h0);
        check("bp_accepted_total", 32'(accepted), 32'h3);
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 32'(sb_q.size()), 32'h0);
        check("bp_final_z", 32'(z), 32'h0003);

        // Clear collides with an advancing operation and a new beat.
        drive(1'b1, 2'b00, 16'h0005, 16'h0005);
        @(posedge clk); #1;
        clr = 1'b1;
        drive(1'b1, 2'b00, 16'h0009, 16'h0009);
        #1 check("clr_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        clr = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 16'h0);
        check("clr_out_valid", 32'(out_valid), 32'h0);
        check("clr_z", 32'(z), 32'h0);
        check("clr_cnt", 32'(cnt), 32'h0);
        check("clr_sticky", 32'(sticky), 32'h0);
        repeat (3) @(posedge clk);
        #1 check("clr_no_late_result", 32'(out_valid), 32'h0);

        // Counter saturation on the CNT_W=2 instance.
        c2_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 c2_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt2_sat", 32'(c2_cnt), 32'h3);
        check("cnt2_z", 32'(c2_z), 32'h0002);
        check("cnt2_out_valid", 32'(c2_out_valid), 32'h0);
        check("cnt2_ovf", 32'(c2_ovf), 32'h0);
        check("cnt2_sticky", 32'(c2_sticky), 32'h0);
        check("cnt2_in_ready", 32'(c2_in_ready), 32'h1);

        // Randomised traffic with a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                clr = 1'b0;
                drive(1'b0, 2'b00, 16'h0, 16'h0);
                check_reset_state("midreset");
            end
            drive($urandom_range(0, 3) != 0, 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        clr = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 16'h0, 16'h0);
        repeat (5) @(posedge clk);
        #1 check("final_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
